// File: rtl/pe_inject_arbiter.sv
// rtl/pe_inject_arbiter.sv - round-robin arbiter feeding one NoC injection port
// Single-flit packets with optional per-source budgets and a sticky done flag.
module pe_inject_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int PKT_LIMIT = 20,
   parameter int VC        = 0,
   parameter int STAMP     = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [3*NUM_REQ-1:0]   req_dest,
   input  logic [32*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [37:0]            o_data,
   output logic                   o_data_valid,
   input  logic                   i_data_ready,
   output logic                   done,
   output logic [31:0]            total_sent
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = 16;
   localparam logic [CW-1:0] LIMIT = CW'(PKT_LIMIT);
   // Unlimited mode saturates at all-ones so the counter still never wraps.
   localparam logic [CW-1:0] CAP = (PKT_LIMIT == 0) ? {CW{1'b1}} : LIMIT;

   logic [PW-1:0]  ptr_q, ptr_d;
   logic [CW-1:0]  sent_q [NUM_REQ];
   logic [CW-1:0]  sent_d [NUM_REQ];
   logic [37:0]    data_q, data_d;
   logic           valid_q, valid_d;
   logic           done_q, done_d;
   logic [31:0]    total_q, total_d;
   logic [31:0]    cyc_q;

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant;
   logic [PW-1:0]      win;
   logic [PW-1:0]      idx;
   logic [PW:0]        sum;
   logic               found;
   logic               load_ok;
   logic               drain;
   logic               acc;
   logic               all_spent_d;
   logic [2:0]         sel_dest;
   logic [31:0]        sel_data;

   assign load_ok = enable && (!valid_q || i_data_ready);
   assign drain   = valid_q && i_data_ready;

   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         eligible[k] = req_valid[k] && !((PKT_LIMIT != 0) && (sent_q[k] == LIMIT));
      end
   end

   // Priority scan starting at the round-robin pointer.
   always_comb begin
      grant = '0;
      win   = '0;
      idx   = '0;
      sum   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(i);
         if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
         idx = sum[PW-1:0];
         if (!found && eligible[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      if (found && load_ok) grant[win] = 1'b1;
   end

   assign acc       = |grant;
   assign req_ready = grant;

   always_comb begin
      sel_dest = '0;
      sel_data = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant[k]) begin
            sel_dest = req_dest[3*k +: 3];
            sel_data = req_data[32*k +: 32];
         end
      end
   end

   always_comb begin
      ptr_d       = ptr_q;
      data_d      = data_q;
      valid_d     = valid_q;
      total_d     = total_q + {31'd0, drain};
      all_spent_d = 1'b1;
      for (int k = 0; k < NUM_REQ; k++) begin
         sent_d[k] = sent_q[k];
         if (grant[k] && sent_q[k] != CAP) sent_d[k] = sent_q[k] + CW'(1);
         if (sent_d[k] != LIMIT) all_spent_d = 1'b0;
      end
      if (acc) begin
         data_d  = {2'b11, sel_dest, 1'(VC), (STAMP != 0) ? cyc_q : sel_data};
         valid_d = 1'b1;
         ptr_d   = (win == PW'(NUM_REQ-1)) ? '0 : win + PW'(1);
      end else if (drain) begin
         data_d  = '0;
         valid_d = 1'b0;
      end
      done_d = done_q || ((PKT_LIMIT != 0) && all_spent_d && !valid_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         total_q <= '0;
         cyc_q   <= '0;
         for (int k = 0; k < NUM_REQ; k++) sent_q[k] <= '0;
      end else begin
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         total_q <= total_d;
         cyc_q   <= cyc_q + 32'd1;
         for (int k = 0; k < NUM_REQ; k++) sent_q[k] <= sent_d[k];
      end
   end

   assign o_data       = data_q;
   assign o_data_valid = valid_q;
   assign done         = done_q;
   assign total_sent   = total_q;

endmodule

// File: tb/tb_pe_inject_arbiter.sv
// tb/tb_pe_inject_arbiter.sv - randomized bench against a behavioural model
// Model tracks budgets, pointer and output slot from the arbitration rules.
module tb_pe_inject_arbiter;

   localparam int N   = 4;
   localparam int LIM = 5;

   logic           clk = 1'b0;
   logic           rst;
   logic           enable;
   logic [N-1:0]   req_valid;
   logic [3*N-1:0] req_dest;
   logic [32*N-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic [37:0]    o_data;
   logic           o_data_valid;
   logic           i_data_ready;
   logic           done;
   logic [31:0]    total_sent;

   pe_inject_arbiter #(.NUM_REQ(N), .PKT_LIMIT(LIM), .VC(1), .STAMP(1)) dut (
      .clk(clk), .rst(rst), .enable(enable), .req_valid(req_valid),
      .req_dest(req_dest), .req_data(req_data), .req_ready(req_ready),
      .o_data(o_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
      .done(done), .total_sent(total_sent)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int          m_ptr;
   int          m_sent [N];
   logic        m_valid;
   logic [37:0] m_data;
   logic [31:0] m_total;
   logic        m_done;
   logic [31:0] m_cyc;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_valid = 1'b0; m_data = '0; m_total = '0; m_done = 1'b0; m_cyc = '0;
      for (int k = 0; k < N; k++) m_sent[k] = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0; enable = 1'b0; i_data_ready = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Called at a negedge; drives one cycle, checks, advances to the next negedge.
   task automatic step(input logic [N-1:0] v, input logic en, input logic rdy);
      int          w;
      logic [N-1:0] exp_ready;
      logic        ok;
      logic        dr;
      req_valid = v; enable = en; i_data_ready = rdy;
      req_dest = 12'($urandom);
      for (int k = 0; k < N; k++) req_data[32*k +: 32] = $urandom;
      #1;
      w = -1;
      ok = en && (!m_valid || rdy);
      for (int off = 0; off < N; off++) begin
         int k;
         k = (m_ptr + off) % N;
         if (w < 0 && v[k] && m_sent[k] < LIM) w = k;
      end
      exp_ready = '0;
      if (ok && w >= 0) exp_ready[w] = 1'b1;
      check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
      check_eq("o_data", 64'(o_data), 64'(m_data));
      check_eq("o_data_valid", 64'(o_data_valid), 64'(m_valid));
      check_eq("done", 64'(done), 64'(m_done));
      check_eq("total_sent", 64'(total_sent), 64'(m_total));
      @(posedge clk);
      dr = m_valid && rdy;
      if (dr) m_total = m_total + 32'd1;
      if (ok && w >= 0) begin
         m_data  = {2'b11, req_dest[3*w +: 3], 1'b1, m_cyc};
         m_valid = 1'b1;
         m_sent[w]++;
         m_ptr = (w + 1) % N;
      end else if (dr) begin
         m_valid = 1'b0;
         m_data  = '0;
      end
      m_cyc = m_cyc + 32'd1;
      begin
         int spent;
         spent = 0;
         for (int k = 0; k < N; k++) if (m_sent[k] == LIM) spent++;
         if (spent == N && !m_valid) m_done = 1'b1;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [2:0] d;
      rst = 1'b1;
      req_valid = '0; req_dest = '0; req_data = '0; enable = 1'b0; i_data_ready = 1'b0;
      #3;
      check_eq("async_reset_valid", 64'(o_data_valid), 64'd0);
      @(negedge clk);
      do_reset();

      for (int i = 0; i < 10; i++) step('0, 1'b1, 1'b1);

      do_reset();
      for (int i = 0; i < 16; i++) step(4'hF, 1'b1, 1'b1);
      check_eq("rr_total16", 64'(total_sent), 64'd15);
      for (int i = 0; i < 4; i++) step(4'hF, 1'b1, 1'b1);
      step(4'hF, 1'b1, 1'b1);
      check_eq("budget_total", 64'(total_sent), 64'd20);
      check_eq("budget_done", 64'(done), 64'd1);
      step(4'hF, 1'b1, 1'b1);

      do_reset();
      step(4'b0100, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(4'hF, 1'b1, 1'b0);
      step('0, 1'b1, 1'b1);
      step('0, 1'b1, 1'b1);

      do_reset();
      for (int i = 0; i < 100; i++) step('0, 1'b1, 1'b1);
      step(4'b0010, 1'b1, 1'b0);
      d = req_dest[5:3];
      check_eq("stamp_payload", 64'(o_data[31:0]), 64'd100);
      check_eq("stamp_head", 64'(o_data[37:36]), 64'd3);
      check_eq("stamp_vc", 64'(o_data[32]), 64'd1);
      check_eq("stamp_dest", 64'(o_data[35:33]), 64'(d));

      do_reset();
      step(4'b0001, 1'b1, 1'b1);
      step(4'hF, 1'b0, 1'b0);
      step(4'hF, 1'b0, 1'b1);
      step(4'hF, 1'b0, 1'b1);
      step(4'hF, 1'b1, 1'b1);
      step(4'hF, 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      check_eq("midrst_valid", 64'(o_data_valid), 64'd0);
      check_eq("midrst_data", 64'(o_data), 64'd0);
      check_eq("midrst_total", 64'(total_sent), 64'd0);
      @(negedge clk);
      do_reset();
      step(4'hF, 1'b1, 1'b1);
      step(4'hF, 1'b1, 1'b1);

      for (int r = 0; r < 4; r++) begin
         do_reset();
         for (int i = 0; i < 250; i++)
            step(4'($urandom), ($urandom % 8) != 0, ($urandom % 4) != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
